// File: rtl/bp_be_pkg.sv
// Shared BE types and address-geometry constants for the prefetch generator and stride detector.
// Pure declarations: no logic, no latency.
package bp_be_pkg;

    localparam int vaddr_width_gp        = 39;
    localparam int dcache_block_width_gp = 512;
    localparam int page_offset_width_gp  = 12;

    function automatic int line_offset_width(input int block_width_bits);
        return $clog2(block_width_bits / 8);
    endfunction

    localparam int line_offset_width_gp = line_offset_width(dcache_block_width_gp);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_gen   = 2'd1,
        e_issue = 2'd2
    } bp_be_pf_gen_state_e;

endpackage

// File: rtl/bp_be_prefetch_gen_if.sv
// Loop-descriptor input and prefetch-address output of the BE prefetch generator.
// master = generator side, slave = profiler/scheduler side.
interface bp_be_prefetch_gen_if
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p  = vaddr_width_gp,
    parameter int stride_width_p = 8,
    parameter int output_range_p = 8
);

    logic                      loop_v_i;
    logic                      loop_ready_and_o;
    logic [vaddr_width_p-1:0]  base_vaddr_i;
    logic [stride_width_p-1:0] stride_i;
    logic [output_range_p-1:0] remaining_iterations_i;
    logic                      pf_v_o;
    logic [vaddr_width_p-1:0]  pf_vaddr_o;
    logic                      pf_yumi_i;

    modport master (
        input  loop_v_i,
        input  base_vaddr_i,
        input  stride_i,
        input  remaining_iterations_i,
        input  pf_yumi_i,
        output loop_ready_and_o,
        output pf_v_o,
        output pf_vaddr_o
    );

    modport slave (
        output loop_v_i,
        output base_vaddr_i,
        output stride_i,
        output remaining_iterations_i,
        output pf_yumi_i,
        input  loop_ready_and_o,
        input  pf_v_o,
        input  pf_vaddr_o
    );

endinterface

// File: rtl/bp_be_dff_reset_en.sv
// Enabled register with synchronous active-low clear to zero.
// One-cycle latency, no handshake.
module bp_be_dff_reset_en #(
    parameter int width_p = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [width_p-1:0] d,
    output logic [width_p-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bp_be_pf_addr_step.sv
// One stride step: next address, cache-line index of cur, and page-cross flag against a latched tag.
// Purely combinational, no handshake.
module bp_be_pf_addr_step
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p       = vaddr_width_gp,
    parameter int stride_width_p      = 8,
    parameter int line_offset_width_p = line_offset_width_gp
) (
    input  logic [vaddr_width_p-1:0]                      cur,
    input  logic [stride_width_p-1:0]                     stride,
    input  logic [vaddr_width_p-page_offset_width_gp-1:0] page_tag,
    output logic [vaddr_width_p-1:0]                      next_vaddr,
    output logic [vaddr_width_p-line_offset_width_p-1:0]  line,
    output logic                                          page_cross
);

    logic [vaddr_width_p-1:0] stride_ext;

    assign stride_ext = {{(vaddr_width_p-stride_width_p){stride[stride_width_p-1]}}, stride};
    assign next_vaddr = cur + stride_ext;
    assign line       = cur[vaddr_width_p-1:line_offset_width_p];
    // Wrap-around past the top of the vaddr space also changes the tag, so it stops the stream too.
    assign page_cross = (cur[vaddr_width_p-1:page_offset_width_gp] != page_tag);

endmodule

// File: rtl/bp_be_prefetch_gen.sv
// Turns one loop descriptor into up to max_pf_p page-bounded, line-deduplicated prefetch vaddrs.
// First pf_v_o two cycles after accept; descriptors back-pressured while busy, pf held until yumi/flush.
module bp_be_prefetch_gen
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p        = vaddr_width_gp,
    parameter int dcache_block_width_p = dcache_block_width_gp,
    parameter int output_range_p       = 8,
    parameter int stride_width_p       = 8,
    parameter int distance_p           = 2,
    parameter int max_pf_p             = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    bp_be_prefetch_gen_if.master  io
);

    localparam int line_off_lp   = line_offset_width(dcache_block_width_p);
    localparam int tag_width_lp  = vaddr_width_p - page_offset_width_gp;
    localparam int line_width_lp = vaddr_width_p - line_off_lp;
    localparam int cnt_width_lp  = $clog2(max_pf_p + 1);

    localparam logic [vaddr_width_p-1:0]  distance_lp    = vaddr_width_p'(distance_p);
    localparam logic [output_range_p-1:0] distance_or_lp = output_range_p'(distance_p);
    localparam logic [output_range_p-1:0] max_pf_or_lp   = output_range_p'(max_pf_p);

    bp_be_pf_gen_state_e state_r, state_n;

    logic [vaddr_width_p-1:0]  cur_r, cur_d, next_vaddr, accept_cur, stride_ext;
    logic [stride_width_p-1:0] stride_r;
    logic [tag_width_lp-1:0]   tag_r;
    logic [line_width_lp-1:0]  last_line_r, cur_line;
    logic                      last_line_v_r, page_cross;
    logic [cnt_width_lp-1:0]   cnt_r, cnt_d, cnt_dec, accept_cnt;
    logic [output_range_p-1:0] avail;
    logic                      accept, take, skip, advance;

    // Descriptor setup: first address sits distance_p strides ahead of the current iteration.
    assign stride_ext = {{(vaddr_width_p-stride_width_p){io.stride_i[stride_width_p-1]}}, io.stride_i};
    assign accept_cur = io.base_vaddr_i + stride_ext * distance_lp;

    always_comb begin
        avail = '0;
        if (io.remaining_iterations_i > distance_or_lp) begin
            avail = io.remaining_iterations_i - distance_or_lp;
        end
        if (avail > max_pf_or_lp) begin
            avail = max_pf_or_lp;
        end
        accept_cnt = cnt_width_lp'(avail);
    end

    assign cnt_dec = cnt_r - cnt_width_lp'(1);

    bp_be_pf_addr_step #(
        .vaddr_width_p      (vaddr_width_p),
        .stride_width_p     (stride_width_p),
        .line_offset_width_p(line_off_lp)
    ) u_step (
        .cur       (cur_r),
        .stride    (stride_r),
        .page_tag  (tag_r),
        .next_vaddr(next_vaddr),
        .line      (cur_line),
        .page_cross(page_cross)
    );

    always_comb begin
        state_n = state_r;
        accept  = 1'b0;
        take    = 1'b0;
        skip    = 1'b0;
        case (state_r)
            e_idle: begin
                if (io.loop_v_i) begin
                    accept = 1'b1;
                    if (accept_cnt != '0) state_n = e_gen;
                end
            end
            e_gen: begin
                if (page_cross) begin
                    state_n = e_idle;
                end else if (last_line_v_r && (cur_line == last_line_r)) begin
                    skip = 1'b1;
                    if (cnt_dec == '0) state_n = e_idle;
                end else begin
                    state_n = e_issue;
                end
            end
            e_issue: begin
                if (io.pf_yumi_i) begin
                    take    = 1'b1;
                    state_n = (cnt_dec == '0) ? e_idle : e_gen;
                end
            end
            default: state_n = e_idle;
        endcase
        // Flush aborts the descriptor and swallows any same-cycle accept or yumi.
        if (flush_i) begin
            state_n = e_idle;
            accept  = 1'b0;
            take    = 1'b0;
            skip    = 1'b0;
        end
    end

    assign advance = skip | take;
    assign cur_d   = accept ? accept_cur : next_vaddr;
    assign cnt_d   = accept ? accept_cnt : cnt_dec;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    bp_be_dff_reset_en #(.width_p(vaddr_width_p)) u_cur (
        .clk(clk_i), .reset_n(reset_i), .en(accept | advance), .d(cur_d), .q(cur_r)
    );

    bp_be_dff_reset_en #(.width_p(cnt_width_lp)) u_cnt (
        .clk(clk_i), .reset_n(reset_i), .en(accept | advance), .d(cnt_d), .q(cnt_r)
    );

    bp_be_dff_reset_en #(.width_p(stride_width_p)) u_stride (
        .clk(clk_i), .reset_n(reset_i), .en(accept), .d(io.stride_i), .q(stride_r)
    );

    bp_be_dff_reset_en #(.width_p(tag_width_lp)) u_tag (
        .clk(clk_i), .reset_n(reset_i), .en(accept),
        .d(io.base_vaddr_i[vaddr_width_p-1:page_offset_width_gp]), .q(tag_r)
    );

    bp_be_dff_reset_en #(.width_p(line_width_lp)) u_last_line (
        .clk(clk_i), .reset_n(reset_i), .en(take), .d(cur_line), .q(last_line_r)
    );

    // Accept clears the dedupe history; each consumed address sets it.
    bp_be_dff_reset_en #(.width_p(1)) u_last_line_v (
        .clk(clk_i), .reset_n(reset_i), .en(accept | take), .d(take), .q(last_line_v_r)
    );

    assign io.loop_ready_and_o = reset_i & ~flush_i & (state_r == e_idle);
    assign io.pf_v_o           = (state_r == e_issue) & ~flush_i;
    assign io.pf_vaddr_o       = cur_r;

endmodule

// File: tb/tb_bp_be_prefetch_gen.sv
// Directed and random descriptors against a closed-form address model with line dedupe and page stop.
module tb_bp_be_prefetch_gen;

    localparam int VW = 39;

    logic clk = 1'b0;
    logic reset_i;
    logic flush_i;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    bp_be_prefetch_gen_if #(.vaddr_width_p(VW), .stride_width_p(8), .output_range_p(8)) bus ();

    bp_be_prefetch_gen #(
        .vaddr_width_p(VW), .dcache_block_width_p(512), .output_range_p(8),
        .stride_width_p(8), .distance_p(2), .max_pf_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .io(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Address i of the stream is base + stride*(2+i); stop at page change, drop repeated lines.
    function automatic int model(input logic [VW-1:0] base, input logic [7:0] stride, input logic [7:0] rem);
        longint s, a, last, mask;
        int n, examined;
        bit last_v;
        s = longint'($signed(stride));
        mask = (longint'(1) << VW) - 1;
        n = (int'(rem) > 2) ? int'(rem) - 2 : 0;
        if (n > 4) n = 4;
        examined = 0;
        last_v = 1'b0;
        last = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = (longint'(base) + s * longint'(2 + i)) & mask;
            examined++;
            if ((a >> 12) != (longint'(base) >> 12)) break;
            if (last_v && ((a >> 6) == last)) continue;
            exp_q.push_back(64'(a));
            last = a >> 6;
            last_v = 1'b1;
        end
        return examined;
    endfunction

    task automatic present(input string tag, input logic [VW-1:0] base, input logic [7:0] stride, input logic [7:0] rem);
        @(negedge clk);
        bus.loop_v_i = 1'b1;
        bus.base_vaddr_i = base;
        bus.stride_i = stride;
        bus.remaining_iterations_i = rem;
        bus.pf_yumi_i = 1'b0;
        #1;
        chk({tag, "_ready_at_accept"}, 64'(bus.loop_ready_and_o), 64'd1);
    endtask

    task automatic wait_pf(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            bus.loop_v_i = 1'b0;
            bus.pf_yumi_i = 1'b0;
            #1;
            k++;
        end while (!bus.pf_v_o && k < 20);
        chk({tag, "_pf_seen"}, 64'(bus.pf_v_o), 64'd1);
    endtask

    task automatic run_desc(input string tag, input logic [VW-1:0] base, input logic [7:0] stride,
                            input logic [7:0] rem, input bit rand_yumi, input int hold);
        int examined, n_exp, issued, stalls, k, held;
        bit done, y;
        examined = model(base, stride, rem);
        n_exp = exp_q.size();
        issued = 0; stalls = 0; held = 0; k = 0; done = 1'b0;
        present(tag, base, stride, rem);
        while (!done && k < 200) begin
            @(negedge clk);
            bus.loop_v_i = 1'b0;
            bus.pf_yumi_i = 1'b0;
            #1;
            k++;
            if (bus.loop_ready_and_o) begin
                done = 1'b1;
            end else if (bus.pf_v_o) begin
                if (exp_q.size() == 0) chk({tag, "_pf_count"}, 64'(issued + 1), 64'(n_exp));
                else chk({tag, "_pf_vaddr"}, 64'(bus.pf_vaddr_o), exp_q[0]);
                y = (held < hold) ? 1'b0 : (rand_yumi ? ($urandom_range(0, 1) == 1) : 1'b1);
                held++;
                if (y) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    issued++;
                end else begin
                    stalls++;
                end
                bus.pf_yumi_i = y;
            end
        end
        chk({tag, "_back_to_idle"}, 64'(done), 64'd1);
        chk({tag, "_pf_v_in_idle"}, 64'(bus.pf_v_o), 64'd0);
        chk({tag, "_issued"}, 64'(issued), 64'(n_exp));
        chk({tag, "_idle_cycle"}, 64'(k), 64'(examined + issued + stalls + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [VW-1:0] base;
        logic [7:0] stride, rem;

        reset_i = 1'b0;
        flush_i = 1'b0;
        bus.loop_v_i = 1'b0;
        bus.base_vaddr_i = '0;
        bus.stride_i = '0;
        bus.remaining_iterations_i = '0;
        bus.pf_yumi_i = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", 64'(bus.loop_ready_and_o), 64'd0);
        chk("reset_pf_v", 64'(bus.pf_v_o), 64'd0);
        chk("reset_pf_vaddr", 64'(bus.pf_vaddr_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("post_reset_ready", 64'(bus.loop_ready_and_o), 64'd1);

        run_desc("basic", 39'h00_8000_1000, 8'd64, 8'd10, 1'b0, 0);
        run_desc("dedupe", 39'h2000, 8'd8, 8'd20, 1'b0, 0);
        run_desc("page_stop", 39'h3F80, 8'd64, 8'd10, 1'b0, 0);
        run_desc("neg_bp", 39'h5400, 8'h80, 8'd6, 1'b0, 5);
        run_desc("stride0", 39'h9000, 8'd0, 8'd10, 1'b0, 0);
        run_desc("rem2", 39'h6000, 8'd64, 8'd2, 1'b0, 0);
        run_desc("rem0", 39'h6000, 8'd64, 8'd0, 1'b0, 0);
        run_desc("rem3", 39'h6000, 8'd64, 8'd3, 1'b0, 0);
        run_desc("wrap", 39'h7F_FFFF_FF80, 8'd64, 8'd10, 1'b0, 0);

        // Flush on the second address together with a yumi.
        present("flush", 39'h00_8000_1000, 8'd64, 8'd10);
        wait_pf("flush_a1");
        chk("flush_addr1", 64'(bus.pf_vaddr_o), 64'h8000_1080);
        bus.pf_yumi_i = 1'b1;
        wait_pf("flush_a2");
        chk("flush_addr2", 64'(bus.pf_vaddr_o), 64'h8000_10C0);
        flush_i = 1'b1;
        bus.pf_yumi_i = 1'b1;
        #1;
        chk("flush_pf_v_masked", 64'(bus.pf_v_o), 64'd0);
        chk("flush_ready_masked", 64'(bus.loop_ready_and_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        bus.pf_yumi_i = 1'b0;
        #1;
        chk("flush_ready_after", 64'(bus.loop_ready_and_o), 64'd1);
        chk("flush_pf_v_after", 64'(bus.pf_v_o), 64'd0);
        chk("flush_yumi_ignored", 64'(bus.pf_vaddr_o), 64'h8000_10C0);

        // First address shares the line last consumed before the flush; accept must forget it.
        run_desc("post_flush", 39'h00_8000_1040, 8'd32, 8'd4, 1'b0, 0);

        // Reset while an address is on offer.
        present("rst_issue", 39'h00_1234_5000, 8'd64, 8'd8);
        wait_pf("rst_issue");
        reset_i = 1'b0;
        #1;
        chk("rst_issue_ready_low", 64'(bus.loop_ready_and_o), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_issue_pf_v", 64'(bus.pf_v_o), 64'd0);
        chk("rst_issue_pf_vaddr", 64'(bus.pf_vaddr_o), 64'd0);
        chk("rst_issue_ready", 64'(bus.loop_ready_and_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("rst_release_ready", 64'(bus.loop_ready_and_o), 64'd1);

        for (int t = 0; t < 40; t++) begin
            base = VW'({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 1) base[11:6] = 6'h3C;
            stride = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) stride = 8'($urandom_range(0, 32)) - 8'd16;
            rem = 8'($urandom_range(0, 9));
            run_desc("rand", base, stride, rem, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
